// File: rtl/conv1d_transpose_engine_pkg.sv
// Shared fixed-point widths, FSM state encoding and sizing helpers for the transposed Conv1D
// engine.
package conv1d_transpose_engine_pkg;

    localparam int unsigned DataWidth   = 16;  // Q8.8 activations and bias
    localparam int unsigned WeightWidth = 8;   // Q1.7 weights
    localparam int unsigned AccWidth    = 32;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StCompute,
        StDrain,
        StOutput,
        StDone
    } state_e;

    // Counter width that never collapses to zero bits.
    function automatic int unsigned cw(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned out_len(input int unsigned frame_len, input int unsigned stride,
                                            input int unsigned kernel, input int unsigned padding);
        return (frame_len - 1) * stride + kernel - 2 * padding;
    endfunction

endpackage

// File: rtl/conv1d_transpose_engine_if.sv
// Valid/ready sample stream; the producer uses master, the consumer uses slave.
interface conv1d_transpose_engine_if #(
    parameter int unsigned DATA_WIDTH = 16
) ();

    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/conv1d_transpose_engine_mac_sat_stage.sv
// Multiply, Q-format shift, accumulate, bias add and 16-bit saturation, shared with the forward
// engine. Build option: define CONVT_LEAKY_RELU_EN for a 0.25-slope leaky ReLU after saturation.
module conv1d_transpose_engine_mac_sat_stage #(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned WEIGHT_WIDTH = 8,
    parameter int unsigned ACC_WIDTH    = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    input  logic                           tap_ok,
    input  logic                           tap_first,
    input  logic                           tap_last,
    input  logic signed [DATA_WIDTH-1:0]   sample,
    input  logic signed [WEIGHT_WIDTH-1:0] weight,
    input  logic signed [DATA_WIDTH-1:0]   bias,
    output logic                           res_valid,
    output logic signed [DATA_WIDTH-1:0]   res
);

    localparam int unsigned ProdW = DATA_WIDTH + WEIGHT_WIDTH;
    localparam int unsigned SumW  = ACC_WIDTH + 1;
    localparam int unsigned Frac  = WEIGHT_WIDTH - 1;
    localparam logic signed [SumW-1:0] SatMax =
        {{(SumW - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [SumW-1:0] SatMin =
        {{(SumW - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

    logic                         v_q, first_q, last_q, res_valid_q;
    logic signed [ProdW-1:0]      mult, prod_q;
    logic signed [DATA_WIDTH-1:0] bias_q, res_q, sat, act;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d, prod_ext, acc_base;
    logic signed [SumW-1:0]       sum;

    always_comb begin
        mult     = ProdW'(sample) * ProdW'(weight);
        prod_ext = ACC_WIDTH'(prod_q) >>> Frac;
        acc_base = first_q ? '0 : acc_q;
        acc_d    = acc_base + prod_ext;
        sum      = SumW'(acc_d) + SumW'(bias_q);
        if (sum > SatMax) begin
            sat = SatMax[DATA_WIDTH-1:0];
        end else if (sum < SatMin) begin
            sat = SatMin[DATA_WIDTH-1:0];
        end else begin
            sat = sum[DATA_WIDTH-1:0];
        end
`ifdef CONVT_LEAKY_RELU_EN
        act = sat[DATA_WIDTH-1] ? (sat >>> 2) : sat;
`else
        act = sat;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q         <= 1'b0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            prod_q      <= '0;
            bias_q      <= '0;
            acc_q       <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
        end else begin
            v_q <= in_valid;
            if (in_valid) begin
                prod_q  <= tap_ok ? mult : '0;
                bias_q  <= bias;
                first_q <= tap_first;
                last_q  <= tap_last;
            end
            res_valid_q <= v_q && last_q;
            if (v_q) begin
                acc_q <= acc_d;
                if (last_q) begin
                    res_q <= act;
                end
            end
        end
    end

    assign res_valid = res_valid_q;
    assign res       = res_q;

endmodule

// File: rtl/conv1d_transpose_engine.sv
// Streaming transposed 1D convolution (gather form): load a frame, compute one tap per cycle,
// then stream results channel-major. Build option CONVT_LEAKY_RELU_EN enables leaky ReLU output.
module conv1d_transpose_engine
    import conv1d_transpose_engine_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DataWidth,
    parameter int unsigned WEIGHT_WIDTH = WeightWidth,
    parameter int unsigned ACC_WIDTH    = AccWidth,
    parameter int unsigned FRAME_LEN    = 8,
    parameter int unsigned IN_CH        = 4,
    parameter int unsigned OUT_CH       = 2,
    parameter int unsigned KERNEL_SIZE  = 4,
    parameter int unsigned STRIDE       = 2,
    parameter int unsigned PADDING      = 1
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    start,
    conv1d_transpose_engine_if.slave                in_if,
    output logic [cw(IN_CH*OUT_CH*KERNEL_SIZE)-1:0] weight_addr,
    input  logic signed [WEIGHT_WIDTH-1:0]          weight_data,
    output logic [cw(OUT_CH)-1:0]                   bias_addr,
    input  logic signed [DATA_WIDTH-1:0]            bias_data,
    conv1d_transpose_engine_if.master               out_if,
    output logic                                    busy,
    output logic                                    done
);

    localparam int unsigned OutLen = out_len(FRAME_LEN, STRIDE, KERNEL_SIZE, PADDING);
    localparam int unsigned NumIn  = IN_CH * FRAME_LEN;
    localparam int unsigned NumOut = OUT_CH * OutLen;
    localparam int unsigned KW     = cw(KERNEL_SIZE);
    localparam int unsigned IcW    = cw(IN_CH);
    localparam int unsigned OW     = cw(OutLen);
    localparam int unsigned OcW    = cw(OUT_CH);
    localparam int unsigned LdW    = cw(NumIn);
    localparam int unsigned OutW   = cw(NumOut);
    localparam int unsigned WaW    = cw(IN_CH * OUT_CH * KERNEL_SIZE);

    state_e                       state_q;
    logic [LdW-1:0]               ld_cnt_q;
    logic [KW-1:0]                k_q;
    logic [IcW-1:0]               ic_q;
    logic [OW-1:0]                o_q;
    logic [OcW-1:0]               oc_q;
    logic [OutW-1:0]              wr_idx_q, rd_idx_q;
    logic                         data_ready_q, out_valid_q, busy_q, done_q;
    logic [DATA_WIDTH-1:0]        data_out_q;
    logic signed [DATA_WIDTH-1:0] in_buf  [NumIn];
    logic signed [DATA_WIDTH-1:0] out_buf [NumOut];

    logic                         s1_valid_q, s1_ok_q, s1_first_q, s1_last_q;
    logic signed [DATA_WIDTH-1:0] s1_sample_q;
    logic                         res_valid;
    logic signed [DATA_WIDTH-1:0] res;

    logic           k_last, ic_last, o_last, oc_last, tap_ok, ld_fire, out_fire;
    int             t_idx;
    logic [LdW-1:0] src_idx;

    assign k_last   = (k_q == KW'(KERNEL_SIZE - 1));
    assign ic_last  = (ic_q == IcW'(IN_CH - 1));
    assign o_last   = (o_q == OW'(OutLen - 1));
    assign oc_last  = (oc_q == OcW'(OUT_CH - 1));
    assign ld_fire  = in_if.valid && data_ready_q;
    assign out_fire = out_valid_q && out_if.ready;

    // Output position o gathers from input t/STRIDE where t = o + PADDING - k.
    always_comb begin
        t_idx   = int'(o_q) + int'(PADDING) - int'(k_q);
        tap_ok  = (t_idx >= 0) && (t_idx % int'(STRIDE) == 0) &&
                  (t_idx / int'(STRIDE) < int'(FRAME_LEN));
        src_idx = '0;
        if (tap_ok) begin
            src_idx = LdW'(int'(ic_q) * int'(FRAME_LEN) + t_idx / int'(STRIDE));
        end
    end

    assign weight_addr = WaW'(int'(oc_q) * int'(IN_CH * KERNEL_SIZE) +
                              int'(ic_q) * int'(KERNEL_SIZE) + int'(k_q));
    assign bias_addr   = oc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            ld_cnt_q     <= '0;
            k_q          <= '0;
            ic_q         <= '0;
            o_q          <= '0;
            oc_q         <= '0;
            rd_idx_q     <= '0;
            data_ready_q <= 1'b0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            data_out_q   <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q      <= StLoad;
                        ld_cnt_q     <= '0;
                        data_ready_q <= 1'b1;
                        busy_q       <= 1'b1;
                    end
                end
                StLoad: begin
                    if (ld_fire) begin
                        ld_cnt_q <= ld_cnt_q + LdW'(1);
                        if (ld_cnt_q == LdW'(NumIn - 1)) begin
                            state_q      <= StCompute;
                            data_ready_q <= 1'b0;
                        end
                    end
                end
                StCompute: begin
                    // Loop nest oc, o, ic, k with k innermost; all wrap to 0 at the end.
                    k_q <= k_last ? '0 : k_q + KW'(1);
                    if (k_last) begin
                        ic_q <= ic_last ? '0 : ic_q + IcW'(1);
                        if (ic_last) begin
                            o_q <= o_last ? '0 : o_q + OW'(1);
                            if (o_last) begin
                                oc_q <= oc_last ? '0 : oc_q + OcW'(1);
                                if (oc_last) begin
                                    state_q <= StDrain;
                                end
                            end
                        end
                    end
                end
                StDrain: begin
                    if (res_valid && wr_idx_q == OutW'(NumOut - 1)) begin
                        state_q     <= StOutput;
                        out_valid_q <= 1'b1;
                        rd_idx_q    <= '0;
                        // Entry 0 is still in flight only when the frame has a single result.
                        data_out_q  <= (wr_idx_q == '0) ? res : out_buf[0];
                    end
                end
                StOutput: begin
                    if (out_fire) begin
                        if (rd_idx_q == OutW'(NumOut - 1)) begin
                            state_q     <= StDone;
                            out_valid_q <= 1'b0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                        end else begin
                            rd_idx_q   <= rd_idx_q + OutW'(1);
                            data_out_q <= out_buf[rd_idx_q + OutW'(1)];
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // S1: sample fetch lines up with the 1-cycle weight and bias ROM reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_ok_q     <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_sample_q <= '0;
            wr_idx_q    <= '0;
        end else begin
            s1_valid_q  <= (state_q == StCompute);
            s1_ok_q     <= tap_ok;
            s1_first_q  <= (ic_q == '0) && (k_q == '0);
            s1_last_q   <= ic_last && k_last;
            s1_sample_q <= tap_ok ? in_buf[src_idx] : '0;
            if (res_valid) begin
                wr_idx_q <= (wr_idx_q == OutW'(NumOut - 1)) ? '0 : wr_idx_q + OutW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ld_fire) begin
            in_buf[ld_cnt_q] <= in_if.data;
        end
        if (res_valid) begin
            out_buf[wr_idx_q] <= res;
        end
    end

    conv1d_transpose_engine_mac_sat_stage #(
        .DATA_WIDTH  (DATA_WIDTH),
        .WEIGHT_WIDTH(WEIGHT_WIDTH),
        .ACC_WIDTH   (ACC_WIDTH)
    ) u_mac (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (s1_valid_q),
        .tap_ok   (s1_ok_q),
        .tap_first(s1_first_q),
        .tap_last (s1_last_q),
        .sample   (s1_sample_q),
        .weight   (weight_data),
        .bias     (bias_data),
        .res_valid(res_valid),
        .res      (res)
    );

    assign in_if.ready  = data_ready_q;
    assign out_if.data  = data_out_q;
    assign out_if.valid = out_valid_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_conv1d_transpose_engine.sv
// Directed bench for conv1d_transpose_engine with default parameters and hand-derived results.
module tb_conv1d_transpose_engine;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [4:0]        weight_addr;
    logic signed [7:0] weight_data;
    logic [0:0]        bias_addr;
    logic signed [15:0] bias_data;
    logic              busy, done;

    conv1d_transpose_engine_if #(.DATA_WIDTH(16)) in_if ();
    conv1d_transpose_engine_if #(.DATA_WIDTH(16)) out_if ();

    conv1d_transpose_engine dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_if      (in_if),
        .weight_addr(weight_addr),
        .weight_data(weight_data),
        .bias_addr  (bias_addr),
        .bias_data  (bias_data),
        .out_if     (out_if),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    logic [7:0]  wmem [32];
    logic [15:0] bmem [2];
    logic [15:0] imem [32];
    logic [15:0] exp_v [32];
    logic [15:0] got [32];
    logic [15:0] ramp_exp [16] = '{16'h0080, 16'h0180, 16'h0180, 16'h0280, 16'h0280, 16'h0380,
                                   16'h0380, 16'h0480, 16'h0480, 16'h0580, 16'h0580, 16'h0680,
                                   16'h0680, 16'h0780, 16'h0780, 16'h0400};
    int tests_run = 0;
    int failures = 0;
    int done_total = 0;

    // Synchronous ROMs with one cycle of latency.
    always @(posedge clk) begin
        weight_data <= wmem[weight_addr];
        bias_data   <= bmem[bias_addr];
    end

    always @(negedge clk) if (done) done_total <= done_total + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic fill_w(input logic [7:0] w);
        for (int i = 0; i < 32; i++) wmem[i] = w;
    endtask

    task automatic fill_in(input logic [15:0] v);
        for (int i = 0; i < 32; i++) imem[i] = v;
    endtask

    task automatic load_frame();
        int guard;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            in_if.valid = 1'b1;
            in_if.data  = imem[i];
            guard = 0;
            while (!in_if.ready && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 100) begin
                check("load_ready_timeout", 32'(guard), 32'd0);
                break;
            end
            @(negedge clk);
        end
        in_if.valid = 1'b0;
        in_if.data  = '0;
    endtask

    task automatic collect(input bit bp, input bit poke_start);
        int nb, cyc, stall;
        bit tog, prev_stalled;
        logic [15:0] prev_data;
        nb = 0; cyc = 0; stall = 0; tog = 1'b1; prev_stalled = 1'b0; prev_data = '0;
        while (nb < 32 && cyc < 3000) begin
            @(negedge clk);
            if (prev_stalled) begin
                check("hold_valid", 32'(out_if.valid), 32'd1);
                check("hold_data", 32'(out_if.data), 32'(prev_data));
            end
            start = poke_start && out_if.valid && (nb == 5);
            if (!bp || nb < 3) begin
                out_if.ready = 1'b1;
            end else if (stall < 5) begin
                out_if.ready = 1'b0;
                stall++;
            end else begin
                out_if.ready = tog;
                tog = !tog;
            end
            prev_stalled = out_if.valid && !out_if.ready;
            prev_data    = out_if.data;
            if (out_if.valid && out_if.ready) begin
                got[nb] = out_if.data;
                nb++;
            end
            cyc++;
        end
        check("beat_count", 32'(nb), 32'd32);
    endtask

    task automatic run_frame(input string name, input bit bp, input bit poke_start);
        int d0;
        load_frame();
        d0 = done_total;
        collect(bp, poke_start);
        @(negedge clk);
        start = 1'b0;
        out_if.ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check({name, "_no_extra_beat"}, 32'(out_if.valid), 32'd0);
        end
        check({name, "_done_once"}, 32'(done_total - d0), 32'd1);
        check({name, "_idle_busy"}, 32'(busy), 32'd0);
        for (int i = 0; i < 32; i++) begin
            check($sformatf("%s[%0d]", name, i), 32'(got[i]), 32'(exp_v[i]));
        end
    endtask

    task automatic set_ramp();
        fill_in(16'h0000);
        for (int p = 0; p < 8; p++) imem[p] = 16'((p + 1) * 256);
        fill_w(8'h40);
        bmem[0] = 16'h0000;
        bmem[1] = 16'h0010;
        for (int o = 0; o < 16; o++) begin
            exp_v[o]      = ramp_exp[o];
            exp_v[16 + o] = ramp_exp[o] + 16'h0010;
        end
    endtask

    initial begin
        in_if.valid = 1'b0;
        in_if.data = '0;
        out_if.ready = 1'b0;
        fill_w(8'h00);
        fill_in(16'h0000);
        bmem[0] = '0;
        bmem[1] = '0;
        repeat (3) @(negedge clk);
        check("rst_data_out", 32'(out_if.data), 32'd0);
        check("rst_valid", 32'(out_if.valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_data_ready", 32'(in_if.ready), 32'd0);
        rst_n = 1'b1;

        // Impulse on ch0 pos0 reaches only o0..o2 with weight 0.5.
        fill_in(16'h0000);
        imem[0] = 16'h0100;
        fill_w(8'h40);
        bmem[0] = 16'h0000;
        bmem[1] = 16'h0000;
        for (int i = 0; i < 32; i++) exp_v[i] = ((i % 16) < 3) ? 16'h0080 : 16'h0000;
        run_frame("impulse", 1'b0, 1'b0);

        fill_in(16'h0000);
        bmem[0] = 16'h0123;
        bmem[1] = 16'hFF00;
        for (int i = 0; i < 32; i++) begin
`ifdef CONVT_LEAKY_RELU_EN
            exp_v[i] = (i < 16) ? 16'h0123 : 16'hFFC0;
`else
            exp_v[i] = (i < 16) ? 16'h0123 : 16'hFF00;
`endif
        end
        run_frame("bias", 1'b0, 1'b0);

        fill_in(16'h7FFF);
        fill_w(8'h7F);
        bmem[0] = 16'h7FFF;
        bmem[1] = 16'h7FFF;
        for (int i = 0; i < 32; i++) exp_v[i] = 16'h7FFF;
        run_frame("sat_pos", 1'b0, 1'b0);

        fill_in(16'h8000);
        for (int i = 0; i < 32; i++) begin
`ifdef CONVT_LEAKY_RELU_EN
            exp_v[i] = 16'hE000;
`else
            exp_v[i] = 16'h8000;
`endif
        end
        run_frame("sat_neg", 1'b0, 1'b0);

        set_ramp();
        run_frame("backpressure", 1'b1, 1'b0);

        // Reset during COMPUTE discards the frame; the next frame must be unaffected.
        set_ramp();
        load_frame();
        repeat (20) @(negedge clk);
        check("mid_compute_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", 32'(out_if.valid), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_data_ready", 32'(in_if.ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        run_frame("after_reset", 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
